vga_timing_gen: RTL and testbench

Free-running VGA raster timing generator that sits directly upstream of the pixel-colour stage (test pattern or framebuffer reader). It maintains horizontal and vertical position counters on the pixel clock and produces registered horizontal/vertical sync, an active-area flag, active-area coordinates and line/frame start strobes. Default parameters give 640x480@60 Hz timing from a 25.175 MHz pixel clock.

---
 rtl/vga_timing_gen.sv | 109 ++++++++++
 tb/tb_vga_timing_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Free-running VGA raster timing generator with registered sync,
//            active-area flag, active coordinates and line/frame strobes.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int HORZ_PIXEL_COUNT = 640,
    parameter int HORZ_FRONT_PORCH = 16,
    parameter int HORZ_SYNC_WIDTH  = 96,
    parameter int HORZ_BACK_PORCH  = 48,
    parameter int VERT_PIXEL_COUNT = 480,
    parameter int VERT_FRONT_PORCH = 10,
    parameter int VERT_SYNC_WIDTH  = 2,
    parameter int VERT_BACK_PORCH  = 33,
    parameter int SYNC_ACTIVE_LOW  = 1
) (
    input  logic        i_pix_clk,
    input  logic        i_reset_n,
    output logic [15:0] o_horz_coord,
    output logic [15:0] o_vert_coord,
    output logic        o_in_active_area,
    output logic        o_horz_sync,
    output logic        o_vert_sync,
    output logic        o_line_start,
    output logic        o_frame_start
);

    localparam int c_H_TOTAL = HORZ_PIXEL_COUNT + HORZ_FRONT_PORCH
                             + HORZ_SYNC_WIDTH + HORZ_BACK_PORCH;
    localparam int c_V_TOTAL = VERT_PIXEL_COUNT + VERT_FRONT_PORCH
                             + VERT_SYNC_WIDTH + VERT_BACK_PORCH;

    localparam logic [15:0] c_H_LAST     = 16'(c_H_TOTAL - 1);
    localparam logic [15:0] c_V_LAST     = 16'(c_V_TOTAL - 1);
    localparam logic [15:0] c_H_ACTIVE   = 16'(HORZ_PIXEL_COUNT);
    localparam logic [15:0] c_V_ACTIVE   = 16'(VERT_PIXEL_COUNT);
    localparam logic [15:0] c_HS_START   = 16'(HORZ_PIXEL_COUNT + HORZ_FRONT_PORCH);
    localparam logic [15:0] c_HS_END     = 16'(HORZ_PIXEL_COUNT + HORZ_FRONT_PORCH
                                               + HORZ_SYNC_WIDTH);
    localparam logic [15:0] c_VS_START   = 16'(VERT_PIXEL_COUNT + VERT_FRONT_PORCH);
    localparam logic [15:0] c_VS_END     = 16'(VERT_PIXEL_COUNT + VERT_FRONT_PORCH
                                               + VERT_SYNC_WIDTH);
    localparam logic        c_SYNC_ON    = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    logic [15:0] r_h;
    logic [15:0] r_v;

    logic        w_active;
    logic        w_hsync_on;
    logic        w_vsync_on;

    logic [15:0] r_horz_coord;
    logic [15:0] r_vert_coord;
    logic        r_in_active_area;
    logic        r_horz_sync;
    logic        r_vert_sync;
    logic        r_line_start;
    logic        r_frame_start;

    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == c_H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == c_V_LAST) ? '0 : r_v + 16'd1;
        end else begin
            r_h <= r_h + 16'd1;
        end
    end

    assign w_active   = (r_h < c_H_ACTIVE) && (r_v < c_V_ACTIVE);
    assign w_hsync_on = (r_h >= c_HS_START) && (r_h < c_HS_END);
    assign w_vsync_on = (r_v >= c_VS_START) && (r_v < c_VS_END);

    // Outputs register the decode of the pre-edge position, so every output
    // lags the counters by exactly one cycle and syncs come straight from flops.
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_horz_coord     <= '0;
            r_vert_coord     <= '0;
            r_in_active_area <= 1'b0;
            r_horz_sync      <= ~c_SYNC_ON;
            r_vert_sync      <= ~c_SYNC_ON;
            r_line_start     <= 1'b0;
            r_frame_start    <= 1'b0;
        end else begin
            r_horz_coord     <= w_active ? r_h : '0;
            r_vert_coord     <= w_active ? r_v : '0;
            r_in_active_area <= w_active;
            r_horz_sync      <= w_hsync_on ? c_SYNC_ON : ~c_SYNC_ON;
            r_vert_sync      <= w_vsync_on ? c_SYNC_ON : ~c_SYNC_ON;
            r_line_start     <= (r_h == 16'd0);
            r_frame_start    <= (r_h == 16'd0) && (r_v == 16'd0);
        end
    end

    assign o_horz_coord     = r_horz_coord;
    assign o_vert_coord     = r_vert_coord;
    assign o_in_active_area = r_in_active_area;
    assign o_horz_sync      = r_horz_sync;
    assign o_vert_sync      = r_vert_sync;
    assign o_line_start     = r_line_start;
    assign o_frame_start    = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Directed self-checking bench for vga_timing_gen (three configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk;
    logic rst_a_n, rst_b_n, rst_c_n;

    logic [15:0] a_hc, a_vc, b_hc, b_vc, c_hc, c_vc;
    logic        a_act, a_hs, a_vs, a_ls, a_fs;
    logic        b_act, b_hs, b_vs, b_ls, b_fs;
    logic        c_act, c_hs, c_vs, c_ls, c_fs;

    int n_checks;
    int n_errors;

    // A: default 640x480 timing, active-low syncs
    vga_timing_gen u_dut_a (
        .i_pix_clk(clk), .i_reset_n(rst_a_n),
        .o_horz_coord(a_hc), .o_vert_coord(a_vc), .o_in_active_area(a_act),
        .o_horz_sync(a_hs), .o_vert_sync(a_vs),
        .o_line_start(a_ls), .o_frame_start(a_fs)
    );

    // B: tiny raster, H_TOTAL 14, V_TOTAL 7
    vga_timing_gen #(
        .HORZ_PIXEL_COUNT(8), .HORZ_FRONT_PORCH(2), .HORZ_SYNC_WIDTH(2), .HORZ_BACK_PORCH(2),
        .VERT_PIXEL_COUNT(4), .VERT_FRONT_PORCH(1), .VERT_SYNC_WIDTH(1), .VERT_BACK_PORCH(1)
    ) u_dut_b (
        .i_pix_clk(clk), .i_reset_n(rst_b_n),
        .o_horz_coord(b_hc), .o_vert_coord(b_vc), .o_in_active_area(b_act),
        .o_horz_sync(b_hs), .o_vert_sync(b_vs),
        .o_line_start(b_ls), .o_frame_start(b_fs)
    );

    // C: default horizontal, short vertical (20/2/2/3 -> 27 lines), active-high syncs
    vga_timing_gen #(
        .VERT_PIXEL_COUNT(20), .VERT_FRONT_PORCH(2), .VERT_SYNC_WIDTH(2), .VERT_BACK_PORCH(3),
        .SYNC_ACTIVE_LOW(0)
    ) u_dut_c (
        .i_pix_clk(clk), .i_reset_n(rst_c_n),
        .o_horz_coord(c_hc), .o_vert_coord(c_vc), .o_in_active_area(c_act),
        .o_horz_sync(c_hs), .o_vert_sync(c_vs),
        .o_line_start(c_ls), .o_frame_start(c_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_cnt, hs_first, hs_last, act_cnt, ls_cnt, ls_h, fs_cnt, vs_cnt;
        int coord_bad, last_fs, vs_first;
        int h, v;
        logic exp_act;
        logic [63:0] exp_vec, got_vec;

        n_checks = 0;
        n_errors = 0;
        rst_a_n  = 1'b0;
        rst_b_n  = 1'b0;
        rst_c_n  = 1'b0;

        // ---------------- reset state ----------------
        repeat (5) @(negedge clk);
        check("a_reset_coords", {a_hc, a_vc}, 32'd0);
        check("a_reset_active", a_act, 1'b0);
        check("a_reset_syncs", {a_hs, a_vs}, 2'b11);
        check("a_reset_strobes", {a_ls, a_fs}, 2'b00);
        check("c_reset_syncs", {c_hs, c_vs}, 2'b00);

        // ---------------- A: line 0 horizontal decode ----------------
        rst_a_n = 1'b1;
        hs_cnt = 0; hs_first = -1; hs_last = -1; act_cnt = 0; ls_cnt = 0;
        for (int p = 0; p <= 800; p++) begin
            @(negedge clk);
            if (p == 0) begin
                check("a_first_active", a_act, 1'b1);
                check("a_first_strobes", {a_ls, a_fs}, 2'b11);
                check("a_first_coords", {a_hc, a_vc}, 32'd0);
            end
            if (p == 639) check("a_coord_639", {a_hc, a_vc}, {16'd639, 16'd0});
            if (p == 640) check("a_coord_640", {a_hc, a_vc, a_act}, 33'd0);
            if (p < 800) begin
                if (a_act) act_cnt++;
                if (!a_hs) begin
                    if (hs_first < 0) hs_first = p;
                    hs_last = p;
                    hs_cnt++;
                end
                if (p > 0 && a_ls) ls_cnt++;
            end else begin
                check("a_line1_start", {a_ls, a_fs}, 2'b10);
                check("a_line1_coords", {a_hc, a_vc, a_act}, {16'd0, 16'd1, 1'b1});
            end
        end
        check("a_active_cnt", act_cnt, 640);
        check("a_hsync_cnt", hs_cnt, 96);
        check("a_hsync_first", hs_first, 656);
        check("a_hsync_last", hs_last, 751);
        check("a_no_extra_ls", ls_cnt, 0);
        check("a_vsync_line0", a_vs, 1'b1);

        // ---------------- B: small raster, full per-cycle model ----------------
        rst_b_n = 1'b1;
        last_fs = -1; vs_cnt = 0; vs_first = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            h = k % 14;
            v = (k / 14) % 7;
            exp_act = (h < 8) && (v < 4);
            exp_vec = {27'd0,
                       exp_act ? 16'(h) : 16'd0,
                       exp_act ? 16'(v) : 16'd0,
                       exp_act,
                       (h >= 10 && h < 12) ? 1'b0 : 1'b1,
                       (v == 5) ? 1'b0 : 1'b1,
                       (h == 0),
                       (h == 0 && v == 0)};
            got_vec = {27'd0, b_hc, b_vc, b_act, b_hs, b_vs, b_ls, b_fs};
            check($sformatf("b_out_k%0d", k), got_vec, exp_vec);
            if (k == 97) check("b_pos_13_6", {b_act, b_ls, b_fs, b_hs, b_vs}, 5'b00011);
            if (k == 98) check("b_wrap_fs", {b_act, b_ls, b_fs, b_hc, b_vc}, {3'b111, 32'd0});
            if (b_fs) begin
                if (last_fs >= 0) check("b_frame_period", k - last_fs, 98);
                last_fs = k;
            end
            if (k < 98 && !b_vs) begin
                if (vs_first < 0) vs_first = k;
                vs_cnt++;
            end
        end
        check("b_vsync_cnt", vs_cnt, 14);
        check("b_vsync_first", vs_first, 70);

        // ---------------- C: active-high syncs and blanking lines ----------------
        rst_c_n = 1'b1;
        for (int ln = 0; ln < 27; ln++) begin
            hs_cnt = 0; hs_first = -1; vs_cnt = 0; act_cnt = 0;
            coord_bad = 0; ls_cnt = 0; ls_h = -1; fs_cnt = 0;
            for (int x = 0; x < 800; x++) begin
                @(negedge clk);
                if (c_hs) begin
                    if (hs_first < 0) hs_first = x;
                    hs_cnt++;
                end
                if (c_vs) vs_cnt++;
                exp_act = (x < 640) && (ln < 20);
                if (c_act) act_cnt++;
                if ({c_hc, c_vc} !== (exp_act ? {16'(x), 16'(ln)} : 32'd0)) coord_bad++;
                if (c_ls) begin
                    ls_cnt++;
                    ls_h = x;
                end
                if (c_fs) fs_cnt++;
            end
            check($sformatf("c_hs_cnt_v%0d", ln), hs_cnt, 96);
            check($sformatf("c_hs_first_v%0d", ln), hs_first, 656);
            check($sformatf("c_vs_cnt_v%0d", ln), vs_cnt, (ln == 22 || ln == 23) ? 800 : 0);
            check($sformatf("c_act_cnt_v%0d", ln), act_cnt, (ln < 20) ? 640 : 0);
            check($sformatf("c_coord_bad_v%0d", ln), coord_bad, 0);
            check($sformatf("c_ls_v%0d", ln), {ls_cnt[7:0], ls_h[15:0]}, {8'd1, 16'd0});
            check($sformatf("c_fs_v%0d", ln), fs_cnt, (ln == 0) ? 1 : 0);
        end
        @(negedge clk);
        check("c_frame_wrap", {c_fs, c_ls, c_act}, 3'b111);

        // ---------------- C: asynchronous reset mid-frame ----------------
        repeat (10 * 800 + 300) @(negedge clk);
        check("c_pre_reset_pos", {c_act, c_hc, c_vc}, {1'b1, 16'd300, 16'd10});
        #1 rst_c_n = 1'b0;
        #1;
        check("c_async_coords", {c_hc, c_vc, c_act}, 33'd0);
        check("c_async_syncs", {c_hs, c_vs}, 2'b00);
        check("c_async_strobes", {c_ls, c_fs}, 2'b00);
        repeat (2) @(negedge clk);
        rst_c_n = 1'b1;
        @(negedge clk);
        check("c_restart", {c_act, c_ls, c_fs, c_hc, c_vc}, {3'b111, 32'd0});
        @(negedge clk);
        check("c_restart_next", {c_act, c_ls, c_fs, c_hc, c_vc}, {3'b100, 16'd1, 16'd0});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
